// File: rtl/fetch_queue_if.sv
// Fetch queue bus: IF PC control, instruction cache port and ID-stage handoff.
// The fetch_queue drives through the master modport; the environment uses slave.
interface fetch_queue_if;
  logic [31:0] pc_in;
  logic        flush;
  logic        load_pc;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  modport master (
    input  pc_in, flush, inst_resp, inst_rdata, id_ready,
    output load_pc, inst_read, inst_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    output pc_in, flush, inst_resp, inst_rdata, id_ready,
    input  load_pc, inst_read, inst_addr, id_valid, id_pc, id_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding I-cache request feeding a DEPTH-entry FIFO toward ID.
// Optional same-cycle response bypass to ID when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_req_pc;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [31:0]   r_pc_mem  [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];

  logic w_issue;
  logic w_accept;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_qvalid;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH-1)) begin
      next_ptr = {AW{1'b0}};
    end else begin
      next_ptr = p + AW'(1);
    end
  endfunction

  // Issue/accept/push/pop decisions for the current cycle
  always_comb begin
    w_issue  = (r_state == ST_IDLE) && (r_count != FULL_CNT) && !bus.flush;
    w_accept = (r_state == ST_WAIT) && bus.inst_resp && !bus.flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass = w_accept && (r_count == {(AW+1){1'b0}}) && bus.id_ready;
`else
    w_bypass = 1'b0;
`endif
    w_push   = w_accept && !w_bypass;
    w_qvalid = (r_count != {(AW+1){1'b0}}) && !bus.flush;
    w_pop    = w_qvalid && bus.id_ready;
  end

  // Output decode; everything is forced to zero while reset is held
  always_comb begin
    bus.inst_read = 1'b0;
    bus.inst_addr = 32'h0000_0000;
    bus.load_pc   = 1'b0;
    bus.id_valid  = 1'b0;
    bus.id_pc     = 32'h0000_0000;
    bus.id_instr  = 32'h0000_0000;
    if (rst) begin
      bus.inst_read = 1'b0;
    end else begin
      bus.inst_read = w_issue || (r_state != ST_IDLE);
      if (w_issue) begin
        bus.inst_addr = bus.pc_in;
      end else if (r_state != ST_IDLE) begin
        bus.inst_addr = r_req_pc;
      end else begin
        bus.inst_addr = 32'h0000_0000;
      end
      bus.load_pc = w_accept || bus.flush;
      if (w_bypass) begin
        bus.id_valid = 1'b1;
        bus.id_pc    = r_req_pc;
        bus.id_instr = bus.inst_rdata;
      end else begin
        bus.id_valid = w_qvalid;
        bus.id_pc    = r_pc_mem[r_head];
        bus.id_instr = r_ins_mem[r_head];
      end
    end
  end

  // Request FSM: a response always closes the request, squashed or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_req_pc <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state  <= ST_WAIT;
            r_req_pc <= bus.pc_in;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.inst_resp) begin
            r_state <= ST_IDLE;
          end else if (bus.flush) begin
            r_state <= ST_DROP;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_DROP: begin
          if (bus.inst_resp) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DROP;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Circular buffer storage and pointers; flush empties the queue without touching entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {(AW+1){1'b0}};
      r_head  <= {AW{1'b0}};
      r_tail  <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]  <= 32'h0000_0000;
        r_ins_mem[i] <= 32'h0000_0000;
      end
    end else if (bus.flush) begin
      r_count <= {(AW+1){1'b0}};
      r_head  <= {AW{1'b0}};
      r_tail  <= {AW{1'b0}};
    end else begin
      if (w_push) begin
        r_pc_mem[r_tail]  <= r_req_pc;
        r_ins_mem[r_tail] <= bus.inst_rdata;
        r_tail            <= next_ptr(r_tail);
      end else begin
        r_tail <= r_tail;
      end
      if (w_pop) begin
        r_head <= next_ptr(r_head);
      end else begin
        r_head <= r_head;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 2, queue entries (power of two, >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pc_in  input  32  current fetch PC from the IF PC register.
REQ-005 flush  input  1  branch mispredict / redirect from IF.
REQ-006 load_pc  output  1  advance/redirect strobe to the IF PC register.
REQ-007 inst_read  output  1  instruction cache read request.
REQ-008 inst_addr  output  32  instruction cache read address.
REQ-009 inst_resp  input  1  instruction cache response valid, one-cycle pulse.
REQ-010 inst_rdata  input  32  instruction word, valid with inst_resp.
REQ-011 id_ready  input  1  ID stage accepts the head entry this cycle.
REQ-012 id_valid  output  1  head entry valid toward ID.
REQ-013 id_pc  output  32  PC of the head entry.
REQ-014 id_instr  output  32  instruction of the head entry.

Function
REQ-015 FSM states: IDLE, WAIT (request outstanding), DROP (squashed request outstanding); at most one outstanding request.
REQ-016 IDLE, count < DEPTH, flush=0: inst_read=1, inst_addr=pc_in, req_pc<=pc_in, next WAIT.
REQ-017 IDLE, count == DEPTH or flush=1: inst_read=0, remain IDLE; inst_resp in IDLE is ignored.
REQ-018 WAIT/DROP: inst_read=1, inst_addr=req_pc held stable until inst_resp.
REQ-019 WAIT, inst_resp=1, flush=0: push {req_pc, inst_rdata} at tail, load_pc=1 for that cycle, next IDLE.
REQ-020 WAIT, flush=1, inst_resp=0: next DROP; WAIT, flush=1, inst_resp=1: response discarded, next IDLE.
REQ-021 DROP, inst_resp=1: response discarded, no push, next IDLE; flush in DROP keeps DROP.
REQ-022 load_pc = (accepted response per REQ-019) OR flush; 0 otherwise.
REQ-023 Queue: circular buffer, head/tail pointers wrap DEPTH-1 -> 0, count range 0..DEPTH.
REQ-024 id_valid = (count != 0) AND NOT flush; id_pc/id_instr = head entry.
REQ-025 Pop when id_valid AND id_ready; simultaneous push and pop leaves count unchanged.
REQ-026 Push never overflows: issue is gated on count < DEPTH and only one request outstanding.
REQ-027 flush: count, head, tail cleared to 0 at that clock edge; no push or pop that cycle.
REQ-028 Without bypass, minimum latency is inst_resp to id_valid = 1 cycle.

Reset
REQ-029 rst=1 asynchronously forces state IDLE, count=0, head=tail=0, req_pc=0, all entries 0.
REQ-030 While rst=1: inst_read=0, load_pc=0, id_valid=0, inst_addr=0, id_pc=0, id_instr=0.
REQ-031 rst during WAIT/DROP abandons the request; a later inst_resp in IDLE is ignored.

Configuration
REQ-032 Macro FETCH_QUEUE_BYPASS_EN defined: in WAIT with count=0, inst_resp=1, flush=0, id_ready=1, the response drives id_valid=1, id_pc=req_pc, id_instr=inst_rdata in the same cycle with no push; load_pc=1.
REQ-033 If the bypass conditions hold except id_ready=0, the response is pushed per REQ-019.
REQ-034 Macro not defined: no bypass; behaviour exactly per REQ-015..REQ-028.

Verification
REQ-035 Reset: rst=1 mid-WAIT -> inst_read=0, id_valid=0, count=0 immediately; the next inst_resp is ignored.
REQ-036 Basic fetch: pc_in=0x60, resp 2 cycles later with rdata=0x00000013, id_ready=1 -> id_valid=1, id_pc=0x60, id_instr=0x13 one cycle after resp (same cycle with FETCH_QUEUE_BYPASS_EN); load_pc pulses once.
REQ-037 Full: id_ready=0, DEPTH=2, fetch 0x60 and 0x64 -> count=2, inst_read=0; id_ready=1 for one cycle -> pop 0x60, new request issued for pc_in next cycle.
REQ-038 Flush in WAIT: flush=1 with 2 entries and outstanding 0x68 -> id_valid=0, count=0, state DROP; resp for 0x68 is discarded, no load_pc on resp; next request uses redirected pc_in=0x100.
REQ-039 Simultaneous flush and inst_resp in WAIT -> response discarded, next IDLE, load_pc=1 that cycle only.
REQ-040 Wrap: 5 fetches 0x0..0x10 with alternating id_ready -> ID receives PCs 0x0,0x4,0x8,0xC,0x10 in order across pointer wrap.
